mem_skew_pingpong: RTL and testbench

//  Double-buffered operand memory for the systolic tpumac array. Loads a DIM x DIM tile
//  row by row into one bank while the other bank streams out as a skewed wavefront.

---
 rtl/mem_skew_pingpong.sv | 137 +++++++++++++
 tb/tb_mem_skew_pingpong.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_skew_pingpong.sv
// Double-buffered DIM x DIM operand tile memory: rows are written into one bank while the
// other bank streams out as a skewed, zero-filled wavefront (lane i delayed by i cycles).
module mem_skew_pingpong #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             tr,
  input  logic                             WrEn,
  input  logic                             Alast,
  input  logic [$clog2(DIM)-1:0]           Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]      Ain,
  output logic                             WrRdy,
  output logic [DIM-1:0][BITS_AB-1:0]      Aout,
  output logic                             Aval,
  output logic                             busy,
  output logic                             done
);

  localparam int            AW    = $clog2(DIM);
  localparam int            KW    = $clog2(2*DIM-1);
  localparam logic [KW-1:0] KLAST = KW'(2*DIM-2);

  typedef logic signed [BITS_AB-1:0] elem_t;
  typedef enum logic {IDLE, STREAM} state_t;

  elem_t         bank [2][DIM][DIM];
  logic [1:0]    full;
  logic          wr_ptr;
  logic          rd_ptr;
  state_t        state;
  logic [KW-1:0] k;
  logic          tr_q;

  logic          wr_acc;
  logic          commit;
  logic          start;
  logic          finish;
  logic          vld_p0;
  logic [KW-1:0] k_sel;
  logic          tr_sel;
  elem_t         wave_p0 [DIM];

  // Write side: a bank accepts rows only while its full flag is clear.
  assign WrRdy  = ~full[wr_ptr];
  assign wr_acc = WrEn & WrRdy;
  assign commit = wr_acc & Alast;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int j = 0; j < DIM; j++) begin
        bank[wr_ptr][Arow][j] <= $signed(Ain[j]);
      end
    end
  end

  // The start cycle emits wavefront 0 with the live tr; later cycles use the latched copy.
  assign start  = (state == IDLE) & en & full[rd_ptr];
  assign vld_p0 = start | ((state == STREAM) & en);
  assign finish = (state == STREAM) & en & (k == KLAST);
  assign k_sel  = start ? '0 : k;
  assign tr_sel = start ? tr : tr_q;

  // Stage p0: pick element (lane, k-lane) or its transpose, zero outside the diagonal band.
  always_comb begin
    int            d;
    logic [AW-1:0] idx;
    logic [AW-1:0] lane;
    d    = 0;
    idx  = '0;
    lane = '0;
    for (int i = 0; i < DIM; i++) begin
      d          = int'(k_sel) - i;
      idx        = AW'(d);
      lane       = AW'(i);
      wave_p0[i] = '0;
      if (d >= 0 && d < DIM) begin
        wave_p0[i] = tr_sel ? bank[rd_ptr][idx][lane] : bank[rd_ptr][lane][idx];
      end
    end
  end

  // Stage p1: registered wavefront plus stream / bank-ownership control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      tr_q   <= 1'b0;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      Aout   <= '0;
      Aval   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      Aval <= vld_p0;
      done <= finish;
      if (vld_p0) begin
        for (int i = 0; i < DIM; i++) begin
          Aout[i] <= wave_p0[i];
        end
      end
      if (commit) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            k     <= KW'(1);
            tr_q  <= tr;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (en) begin
            if (finish) begin
              state        <= IDLE;
              k            <= '0;
              busy         <= 1'b0;
              full[rd_ptr] <= 1'b0;
              rd_ptr       <= ~rd_ptr;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_skew_pingpong.sv
// Randomized bench for mem_skew_pingpong against a tile-queue reference model.
module tb_mem_skew_pingpong;

  localparam int D  = 8;
  localparam int W  = 8;
  localparam int AW = $clog2(D);
  localparam int KL = 2*D-2;

  typedef logic [D*D*W-1:0]    tile_t;
  typedef logic [D-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          tr = 1'b0;
  logic          wren = 1'b0;
  logic          alast = 1'b0;
  logic [AW-1:0] arow = '0;
  vec_t          ain = '0;
  logic          wrrdy;
  vec_t          aout;
  logic          aval;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: committed-but-unfinished tiles in order, plus the tile being written.
  tile_t q[$];
  tile_t wt = '0;
  bit    m_stream = 0;
  int    m_k = 0;
  bit    m_tr = 0;
  vec_t  e_aout = '0;
  bit    e_aval = 0;
  bit    e_done = 0;
  bit    e_busy = 0;
  bit    e_wrrdy = 1;

  mem_skew_pingpong #(.BITS_AB(W), .DIM(D)) dut (
    .clk(clk), .rst(rst), .en(en), .tr(tr), .WrEn(wren), .Alast(alast), .Arow(arow),
    .Ain(ain), .WrRdy(wrrdy), .Aout(aout), .Aval(aval), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic vec_t wave(input tile_t t, input int kk, input bit trn);
    vec_t v;
    int   d;
    v = '0;
    for (int i = 0; i < D; i++) begin
      d = kk - i;
      if (d >= 0 && d < D) v[i] = trn ? t[(d*D+i)*W +: W] : t[(i*D+d)*W +: W];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return 8'h80;
      1:       return 8'h7f;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int e = 0; e < D*D; e++) t[e*W +: W] = pick();
    return t;
  endfunction

  function automatic tile_t seq_tile();
    tile_t t;
    for (int e = 0; e < D*D; e++) t[e*W +: W] = W'(e);
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stream = 0; m_k = 0;
    e_aout = '0; e_aval = 0; e_done = 0; e_busy = 0; e_wrrdy = 1;
  endtask

  // One clock edge: apply the current inputs to the model, then settle past the edge.
  task automatic step();
    bit rdy;
    bit fire;
    @(posedge clk);
    rdy    = (q.size() < 2);
    fire   = 0;
    e_aval = 0;
    e_done = 0;
    if (!m_stream && en && q.size() > 0) begin
      m_stream = 1; m_tr = tr; m_k = 0; fire = 1;
    end else if (m_stream && en) begin
      fire = 1;
    end
    if (fire) begin
      e_aout = wave(q[0], m_k, m_tr);
      e_aval = 1;
      if (m_k == KL) begin
        e_done = 1; m_stream = 0; void'(q.pop_front());
      end else begin
        m_k++;
      end
    end
    if (wren && rdy) begin
      wt[int'(arow)*D*W +: D*W] = ain;
      if (alast) q.push_back(wt);
    end
    e_busy  = m_stream;
    e_wrrdy = (q.size() < 2);
    cyc++;
    #1;
  endtask

  task automatic load_tile(input tile_t t);
    int guard;
    guard = 0;
    for (int r = 0; r < D; r++) begin
      wren = 0; alast = 0;
      while (q.size() >= 2 && guard < 200) begin step(); guard++; end
      wren = 1; arow = AW'(r); ain = t[r*D*W +: D*W]; alast = (r == D-1);
      step();
    end
    wren = 0; alast = 0;
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL load_wait: write bank never freed, waited=%0d required<200", guard);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (aout !== '0 || aval !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrrdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got aout=%h aval=%b busy=%b done=%b wrrdy=%b, required 0,0,0,0,1",
               aout, aval, busy, done, wrrdy);
    end
    rst = 0;
    en  = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (aval !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_empty_en: got aval=%b busy=%b, required 0,0", aval, busy);
      end
    end
    en = 0;
  endtask

  task automatic test_ramp();
    int nval;
    nval = 0;
    tr = 0;
    load_tile(seq_tile());
    en = 1;
    for (int c = 0; c < 2*D+3; c++) begin
      step();
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL ramp cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
      if (aval === 1'b1) begin
        nval++;
        if (nval == 1) begin
          checks++;
          if (aout !== '0) begin
            errors++; $display("FAIL ramp_k0: got %h required all zero", aout);
          end
        end
        if (nval == 2) begin
          checks++;
          if (aout[0] !== 8'd1 || aout[1] !== 8'd8) begin
            errors++; $display("FAIL ramp_k1: got lane0=%0d lane1=%0d required 1,8", aout[0], aout[1]);
          end
        end
        if (nval == 2*D-1) begin
          checks++;
          if (aout[D-1] !== 8'd63 || done !== 1'b1) begin
            errors++; $display("FAIL ramp_k14: got lane7=%0d done=%b required 63,1", aout[D-1], done);
          end
        end
      end
    end
    checks++;
    if (nval != 2*D-1) begin
      errors++; $display("FAIL ramp_aval_count: got %0d required %0d", nval, 2*D-1);
    end
    en = 0;
  endtask

  task automatic test_transpose();
    int nval;
    nval = 0;
    load_tile(seq_tile());
    tr = 1;
    en = 1;
    for (int c = 0; c < 2*D+2; c++) begin
      step();
      tr = 0;
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL transpose cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
      if (aval === 1'b1) begin
        nval++;
        if (nval == 2) begin
          checks++;
          if (aout[0] !== 8'd8 || aout[1] !== 8'd1) begin
            errors++; $display("FAIL transpose_k1: got lane0=%0d lane1=%0d required 8,1", aout[0], aout[1]);
          end
        end
        if (nval >= D && nval <= 2*D-1) begin
          checks++;
          if (aout[D-1] !== W'((nval-D)*D + D-1)) begin
            errors++;
            $display("FAIL transpose_lane7 k=%0d: got %0d required %0d", nval-1, aout[D-1], (nval-D)*D + D-1);
          end
        end
      end
    end
    en = 0;
  endtask

  task automatic test_stall();
    int   nval;
    int   hold;
    bit   stalled;
    vec_t saved;
    nval = 0; hold = 0; stalled = 0; saved = '0;
    tr = 0;
    load_tile(rand_tile());
    en = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL stall cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
      if (aval === 1'b1) nval++;
      if (hold > 0) begin
        checks++;
        if (aval !== 1'b0 || aout !== saved) begin
          errors++; $display("FAIL stall_hold: got aval=%b aout=%h required 0,%h", aval, aout, saved);
        end
        hold--;
        if (hold == 0) en = 1;
      end else if (aval === 1'b1 && nval == 6 && !stalled) begin
        stalled = 1; saved = aout; en = 0; hold = 3;
      end
      if (done === 1'b1) break;
    end
    checks++;
    if (nval != 2*D-1 || done !== 1'b1) begin
      errors++; $display("FAIL stall_total: got %0d wavefronts done=%b required %0d,1", nval, done, 2*D-1);
    end
    en = 0;
  endtask

  task automatic test_back_to_back();
    tile_t b;
    int    r;
    int    phase;
    int    natt;
    int    ndone;
    int    done1;
    b = rand_tile();
    r = 0; phase = 0; natt = 0; ndone = 0; done1 = -1;
    load_tile(rand_tile());
    tr = 1'($urandom);
    en = 1;
    for (int cy = 0; cy < 80 && ndone < 2; cy++) begin
      if (phase == 0) begin
        wren = 1; arow = AW'(r); ain = b[r*D*W +: D*W]; alast = (r == D-1);
      end else if (phase == 1) begin
        checks++;
        if (wrrdy !== 1'b0) begin
          errors++; $display("FAIL pp_wrrdy_full: got %b required 0", wrrdy);
        end
        wren = 1; arow = AW'($urandom); ain = vec_t'({$urandom, $urandom}); alast = 1;
      end else begin
        wren = 0; alast = 0;
      end
      step();
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL pingpong cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
      if (phase == 0) begin
        r++;
        if (r == D) phase = 1;
      end else if (phase == 1) begin
        natt++;
        if (natt == 3) phase = 2;
      end
      if (done1 >= 0 && cy == done1 + 1) begin
        checks++;
        if (aval !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL pp_no_bubble: got aval=%b busy=%b required 1,1", aval, busy);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) done1 = cy;
      end
    end
    checks++;
    if (ndone != 2) begin
      errors++; $display("FAIL pp_done_count: got %0d required 2", ndone);
    end
    wren = 0; alast = 0; en = 0;
  endtask

  task automatic test_edge_values();
    tile_t t;
    int    ord[9] = '{5, 3, 0, 7, 1, 3, 2, 6, 4};
    int    nval;
    nval = 0;
    t = rand_tile();
    for (int c = 0; c < D; c++) begin
      t[c*W +: W]       = (c % 2 == 0) ? 8'h80 : 8'h7f;
      t[(3*D+c)*W +: W] = 8'h80;
    end
    tr = 0;
    for (int i = 0; i < 9; i++) begin
      wren = 1; arow = AW'(ord[i]); alast = (i == 8);
      ain  = (i == 1) ? {D{8'h11}} : t[ord[i]*D*W +: D*W];
      step();
    end
    wren = 0; alast = 0;
    en = 1;
    for (int c = 0; c < 2*D+1; c++) begin
      step();
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL edge cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
      if (aval === 1'b1) begin
        nval++;
        if (nval == 1) begin
          checks++;
          if (aout[0] !== 8'h80) begin
            errors++; $display("FAIL edge_min: got %h required 80", aout[0]);
          end
        end
        if (nval == 4) begin
          checks++;
          if (aout[0] !== 8'h7f || aout[3] !== 8'h80) begin
            errors++; $display("FAIL edge_rewrite: got lane0=%h lane3=%h required 7f,80", aout[0], aout[3]);
          end
        end
      end
    end
    en = 0;
  endtask

  task automatic test_random();
    int  r;
    bit  rdy_b;
    r = 0;
    for (int c = 0; c < 600; c++) begin
      en    = ($urandom % 4) != 0;
      tr    = 1'($urandom);
      wren  = ($urandom % 3) != 0;
      arow  = AW'(r);
      for (int j = 0; j < D; j++) ain[j] = pick();
      alast = (r == D-1);
      rdy_b = (q.size() < 2);
      step();
      if (wren && rdy_b) r = (r + 1) % D;
      checks++;
      if (aout !== e_aout || aval !== e_aval || done !== e_done || wrrdy !== e_wrrdy ||
          (!e_done && busy !== e_busy)) begin
        errors++;
        $display("FAIL random cyc=%0d got aout=%h aval=%b done=%b busy=%b wrrdy=%b, required aout=%h aval=%b done=%b busy=%b wrrdy=%b",
                 cyc, aout, aval, done, busy, wrrdy, e_aout, e_aval, e_done, e_busy, e_wrrdy);
      end
    end
    wren = 0; alast = 0;
    en = 1;
    for (int c = 0; c < 4*D && (m_stream || q.size() > 0); c++) step();
    en = 0;
  endtask

  task automatic test_mid_reset();
    int nval;
    nval = 0;
    load_tile(rand_tile());
    load_tile(rand_tile());
    en = 1;
    for (int c = 0; c < 10 && nval < 5; c++) begin
      step();
      if (aval === 1'b1) nval++;
    end
    rst = 1;
    #1;
    model_reset();
    checks++;
    if (aout !== '0 || aval !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrrdy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got aout=%h aval=%b busy=%b done=%b wrrdy=%b, required 0,0,0,0,1",
               aout, aval, busy, done, wrrdy);
    end
    @(posedge clk);
    #1;
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (aval !== e_aval || busy !== e_busy || wrrdy !== e_wrrdy || aout !== e_aout) begin
        errors++;
        $display("FAIL midreset_nostart: got aval=%b busy=%b wrrdy=%b aout=%h, required %b,%b,%b,%h",
                 aval, busy, wrrdy, aout, e_aval, e_busy, e_wrrdy, e_aout);
      end
    end
    en = 0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_transpose();
    test_stall();
    test_back_to_back();
    test_edge_values();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
